flashctrl_debug_capture: RTL
============================

# flashctrl_debug_capture

Trigger-and-capture sequencer for the flash controller debug buses. Selects one of the 128-bit debug words, waits for a masked match, then records a fixed-length window into an on-chip buffer that software or the VIO reads back by address. Sits beside the ILA/VIO debug wrapper in the flash controller and gives repeatable in-fabric captures without JTAG trigger setup.

## Interface
- NUM_SRC, 11, number of 128-bit debug sources
- DATA_W, 128, width of each debug source
- DEPTH, 512, capture buffer entries (power of two)
- AW, 9, log2(DEPTH)

- v_clk0  in  1  sole clock
- v_rst0  in  1  reset; synchronous, active-high
- v_debug_in  in  NUM_SRC*DATA_W  flattened sources; source i at bits [i*DATA_W +: DATA_W]
- arm  in  1  single-cycle pulse; start a capture
- abort  in  1  single-cycle pulse; return to IDLE
- src_sel  in  4  source index, latched on arm
- trig_mask  in  DATA_W  compare mask, latched on arm
- trig_value  in  DATA_W  compare value, latched on arm
- capture_len  in  AW+1  samples to record, latched on arm
- rd_addr  in  AW  readback address
- rd_data  out  DATA_W  buffer word at rd_addr
- state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
- done  out  1  high while in DONE
- count  out  AW+1  samples written this capture

## Operation
- Input stage: all sources registered once (sel_q = registered, selected source). src_sel ≥ NUM_SRC selects all-zeros.
- Latched config is taken on an accepted arm; later changes to the inputs have no effect until the next arm.
- Effective length: capture_len 0 or > DEPTH gives DEPTH.
- IDLE: arm → ARMED, count ← 0.
- ARMED: match = ((sel_q ^ value_l) & mask_l) == 0. On match → CAPTURE; the matching sel_q is written to addr 0. An all-zero mask matches on the first ARMED cycle.
- CAPTURE: sel_q is written to addr count each cycle and count increments. When count reaches effective length → DONE.
- DONE: holds the buffer and count. arm → ARMED (re-arm; count cleared). Buffer contents are overwritten only by the new capture.
- arm in ARMED or CAPTURE: ignored.
- abort in any state → IDLE. count holds its value and the buffer is not cleared. Simultaneous arm+abort: abort wins.
- Write address never exceeds DEPTH−1; there is no wrap-around.

## Timing
- Reset values: state=IDLE(0), done=0, count=0, latched config=0, rd_data=0. Buffer contents are undefined after reset.
- Input register adds 1 cycle: a source value at cycle t is sel_q at t+1.
- If sel_q matches in ARMED at cycle k:
  - state=CAPTURE at k+1;
  - entry 0 is written at the edge ending cycle k;
  - entries 1..L−1 hold sel_q from cycles k+1..k+L−1;
  - state=DONE and done=1 at cycle k+L, with count=L.
- Arm latency: arm at cycle a gives state=ARMED at a+1. The first compared sample is sel_q at a+1.
- Readback: rd_data is registered, with 1-cycle latency from rd_addr. Reading during CAPTURE returns the old or the new word; either is acceptable and verification must not check it.
- Abort at cycle t gives state=IDLE at t+1. Any write in cycle t still occurs.

## Structure
- Package flashctrl_debug_pkg holds:
  - state enum (IDLE/ARMED/CAPTURE/DONE);
  - DATA_W and NUM_SRC defaults;
  - the effective-length helper function.
- Sub-module debug_capture_ram: simple dual-port, one write port and one registered read port, DEPTH×DATA_W. It infers BRAM.
- The FSM, input register, compare and counter live in the top module.

## Test plan
- Mask=0, len=4, arm: state goes ARMED then CAPTURE on the next cycle; after 4 writes done=1 and count=4. Entries 0..3 equal the source on 4 consecutive cycles.
- src_sel=3, mask=0xFF, value=0x5A; source 3 ramps 0x00..0xFF: trigger fires at 0x5A; entry 0=0x5A, entry 1=0x5B.
- len=0: capture runs to count=512 and entry 511 is written; a read of addr 511 after DONE returns the expected value one cycle after rd_addr.
- Abort mid-CAPTURE at count=7: state=IDLE next cycle and count stays 7. Simultaneous arm+abort in DONE gives IDLE.
- Change src_sel/mask while ARMED: trigger follows the latched config only. A second arm in ARMED is ignored; re-arm from DONE clears count to 0.
- src_sel=12: sel_q=0; value=0, mask=all-ones triggers immediately and the buffer records zeros.

Source files
------------

// File: rtl/flashctrl_debug_pkg.sv
// rtl/flashctrl_debug_pkg.sv - shared types, defaults and helpers for the debug capture sequencer
package flashctrl_debug_pkg;

  localparam int DEF_NUM_SRC = 11;
  localparam int DEF_DATA_W  = 128;
  localparam int DEF_DEPTH   = 512;
  localparam int DEF_AW      = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  // A zero or over-long request means "fill the whole buffer".
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned depth);
    if (len == 0 || len > depth) return depth;
    return len;
  endfunction

endpackage

// File: rtl/debug_capture_ram.sv
// rtl/debug_capture_ram.sv - simple dual-port capture buffer with registered read
module debug_capture_ram #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 512,
  parameter int AW     = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  // Write port: no reset on the array so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read data selected combinationally, then held in the output register.
  always_comb begin
    rd_data_d = mem[rd_addr];
  end

  // Output register with synchronous reset, one cycle of read latency.
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/flashctrl_debug_capture.sv
// rtl/flashctrl_debug_capture.sv - trigger-and-capture sequencer for flash controller debug buses
module flashctrl_debug_capture
  import flashctrl_debug_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AW      = DEF_AW
) (
  input  logic                      v_clk0,
  input  logic                      v_rst0,
  input  logic [NUM_SRC*DATA_W-1:0] v_debug_in,
  input  logic                      arm,
  input  logic                      abort,
  input  logic [3:0]                src_sel,
  input  logic [DATA_W-1:0]         trig_mask,
  input  logic [DATA_W-1:0]         trig_value,
  input  logic [AW:0]               capture_len,
  input  logic [AW-1:0]             rd_addr,
  output logic [DATA_W-1:0]         rd_data,
  output logic [1:0]                state,
  output logic                      done,
  output logic [AW:0]               count
);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_ARMED   = ST_ARMED;
  localparam logic [1:0] S_CAPTURE = ST_CAPTURE;
  localparam logic [1:0] S_DONE    = ST_DONE;

  logic [1:0]        state_q, state_d;
  logic [AW:0]       count_q, count_d;
  logic [AW:0]       len_q, len_d;
  logic [3:0]        src_q, src_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic [DATA_W-1:0] sel_q, sel_d;

  logic              arm_ok;
  logic [3:0]        mux_sel;
  logic              match;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;

  // Arm is only honoured from IDLE or DONE, and never alongside abort.
  always_comb begin
    arm_ok  = arm && !abort && (state_q == S_IDLE || state_q == S_DONE);
    // On the arming cycle the new selection is not latched yet, so use it
    // directly; that makes sel_q one cycle later already the new source.
    mux_sel = arm_ok ? src_sel : src_q;
    match   = (((sel_q ^ value_q) & mask_q) == '0);
  end

  // Source select; out-of-range indices read as all-zeros.
  always_comb begin
    sel_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mux_sel == 4'(i)) sel_d = v_debug_in[i*DATA_W +: DATA_W];
    end
  end

  // Sequencer: config latch, trigger compare, write address and counter.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    src_d   = src_q;
    mask_d  = mask_q;
    value_d = value_q;
    wr_en   = 1'b0;
    wr_addr = count_q[AW-1:0];

    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm_ok) begin
          state_d = S_ARMED;
          count_d = '0;
          src_d   = src_sel;
          mask_d  = trig_mask;
          value_d = trig_value;
          len_d   = (AW+1)'(eff_len(32'(capture_len), 32'(DEPTH)));
        end
      end
      S_ARMED: begin
        if (match) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          count_d = (AW+1)'(1);
          // A one-sample window is complete with the trigger word itself.
          state_d = (len_q == (AW+1)'(1)) ? S_DONE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        wr_en   = 1'b1;
        count_d = count_q + (AW+1)'(1);
        if (count_q + (AW+1)'(1) == len_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything; this cycle's write still lands but the
    // counter freezes so software can see how far the capture got.
    if (abort) begin
      state_d = S_IDLE;
      count_d = count_q;
    end
  end

  // State and configuration registers with synchronous reset.
  always_ff @(posedge v_clk0) begin
    if (v_rst0) begin
      state_q <= S_IDLE;
      count_q <= '0;
      len_q   <= '0;
      src_q   <= '0;
      mask_q  <= '0;
      value_q <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      src_q   <= src_d;
      mask_q  <= mask_d;
      value_q <= value_d;
      sel_q   <= sel_d;
    end
  end

  debug_capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (v_clk0),
    .rst     (v_rst0),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (sel_q),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign state = state_q;
  assign done  = (state_q == S_DONE);
  assign count = count_q;

endmodule
